// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and word geometry.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_RECV  = 3'd0,
      ST_WRITE = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int BCNT_W         = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four accepted bytes into one little-endian 32-bit word and flags
// the byte that completes it.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic        word_ready,
   output logic [31:0] word
);

   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [31:0]       asm_q, asm_d;

   always_comb begin
      bcnt_d     = bcnt_q;
      asm_d      = asm_q;
      word_ready = 1'b0;
      if (clear) begin
         bcnt_d = '0;
         asm_d  = '0;
      end else if (accept) begin
         for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (bcnt_q == BCNT_W'(k)) asm_d[8*k +: 8] = byte_in;
         end
         // The counter wraps to zero on the fourth byte, ready for the next word.
         bcnt_d     = bcnt_q + BCNT_W'(1);
         word_ready = (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1));
      end
      word = asm_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt_q <= '0;
         asm_q  <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         asm_q  <= asm_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory, verifies
// its XOR checksum and releases the pipeline reset once the image is good.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 5,
   parameter int NUM_WORDS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic        accept;
   logic        pack_accept;
   logic        restart;
   logic        word_ready;
   logic [31:0] word;

   // Every output is a decode of registered state, so byte_ready never
   // depends combinationally on byte_valid.
   assign byte_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
   assign imem_we    = (state_q == ST_WRITE);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rst    = (state_q != ST_DONE);
   assign busy       = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
   assign done       = (state_q == ST_DONE);
   assign err        = (state_q == ST_ERR);

   assign accept      = byte_valid && byte_ready;
   assign pack_accept = accept && (state_q == ST_RECV);
   assign restart     = start && ((state_q == ST_DONE) || (state_q == ST_ERR));

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (restart),
      .accept     (pack_accept),
      .byte_in    (byte_in),
      .word_ready (word_ready),
      .word       (word)
   );

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      case (state_q)
         ST_RECV: begin
            if (pack_accept) begin
               csum_d = csum_q ^ byte_in;
               // Capture address and data once so they hold steady after the strobe.
               if (word_ready) begin
                  state_d = ST_WRITE;
                  addr_d  = word_idx_q;
                  wdata_d = word;
               end
            end
         end
         ST_WRITE: begin
            word_idx_d = word_idx_q + ADDR_W'(1);
            state_d    = (word_idx_q == ADDR_W'(NUM_WORDS - 1)) ? ST_CHECK : ST_RECV;
         end
         ST_CHECK: begin
            if (accept) state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
         end
         ST_DONE, ST_ERR: begin
            if (restart) begin
               state_d    = ST_RECV;
               word_idx_d = '0;
               csum_d     = '0;
            end
         end
         default: state_d = ST_RECV;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RECV;
         word_idx_q <= '0;
         csum_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: images are loaded with random gaps and
// checked against an image-level model of writes, checksum and status.
module tb_imem_loader;

   localparam int AW = 5;
   localparam int NW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst;
   logic          busy;
   logic          done;
   logic          err;

   int n_vec = 0;
   int n_bad = 0;

   logic [AW+31:0] exp_q[$];
   logic [AW+31:0] mon_e;
   logic [31:0]    img    [NW];
   logic [31:0]    tb_mem [NW];
   logic [AW-1:0]  last_addr = '0;
   logic [31:0]    last_data = '0;
   logic           rst_seen  = 1'b0;
   logic           mon_en    = 1'b0;

   imem_loader #(.ADDR_W(AW), .NUM_WORDS(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Write monitor and scoreboard: every strobe must match the oldest expected
   // write, and address/data must hold between strobes.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_seen) begin
            last_addr = '0;
            last_data = '0;
         end
         rst_seen = rst;
         if (imem_we) begin
            check_eq("we_ready_low", byte_ready, 1'b0);
            if (exp_q.size() == 0) begin
               check_eq("unexpected_we", imem_we, 1'b0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("we_addr", imem_addr, mon_e[AW+31:32]);
               check_eq("we_data", imem_wdata, mon_e[31:0]);
            end
            if (int'(imem_addr) < NW) tb_mem[imem_addr] = imem_wdata;
            last_addr = imem_addr;
            last_data = imem_wdata;
         end else begin
            check_eq("hold_addr", imem_addr, last_addr);
            check_eq("hold_data", imem_wdata, last_data);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] xor_img();
      logic [7:0] x = 8'h00;
      for (int i = 0; i < NW; i++)
         for (int k = 0; k < 4; k++) x ^= img[i][8*k +: 8];
      return x;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int waited = 0;
      int gap    = int'($urandom_range(gap_max, 0));
      if (gap > 0) begin
         byte_valid = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
      byte_in    = b;
      byte_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (byte_ready) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         waited++;
         if (waited > 50) begin
            check_eq("byte_timeout", waited, 0);
            break;
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input int i, input int gap_max);
      exp_q.push_back({AW'(i), img[i]});
      for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], gap_max);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Sends words first..NW-1 and a checksum (corrupted when good=0), then
   // checks the final status against the expected outcome.
   task automatic load_image(input bit good, input int gap_max, input int first);
      logic [7:0] chk;
      for (int i = first; i < NW; i++) send_word(i, gap_max);
      chk = xor_img();
      if (!good) chk ^= 8'($urandom_range(255, 1));
      send_byte(chk, gap_max);
      @(negedge clk);
      check_eq("done", done, good);
      check_eq("err", err, !good);
      check_eq("cpu_rst", cpu_rst, !good);
      check_eq("busy_end", busy, 1'b0);
      check_eq("ready_end", byte_ready, 1'b0);
      check_eq("q_drained", exp_q.size(), 0);
      if (good)
         for (int i = 0; i < NW; i++) check_eq("mem_word", tb_mem[i], img[i]);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_state();
      check_eq("rst_cpu_rst", cpu_rst, 1'b1);
      check_eq("rst_busy", busy, 1'b1);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_ready", byte_ready, 1'b1);
      check_eq("rst_we", imem_we, 1'b0);
      check_eq("rst_addr", imem_addr, '0);
      check_eq("rst_wdata", imem_wdata, '0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      for (int i = 0; i < NW; i++) tb_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Fixed image: strobe timing and first word, then a clean finish.
      img[0] = 32'h20100013;
      img[1] = 32'h04030201;
      send_word(0, 0);
      @(negedge clk);
      check_eq("t1_we", imem_we, 1'b1);
      check_eq("t1_ready", byte_ready, 1'b0);
      check_eq("t1_addr", imem_addr, 0);
      check_eq("t1_wdata", imem_wdata, 32'h20100013);
      @(posedge clk); #1;
      load_image(1'b1, 0, 1);

      // Bad checksum, then bytes offered while in ERR must be ignored.
      start_pulse();
      load_image(1'b0, 0, 0);
      byte_in    = 8'hAA;
      byte_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_eq("err_hold", err, 1'b1);
         check_eq("err_ready", byte_ready, 1'b0);
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;

      // Restart from ERR and reload correctly.
      start_pulse();
      @(negedge clk);
      check_eq("rs_err", err, 1'b0);
      check_eq("rs_cpu_rst", cpu_rst, 1'b1);
      check_eq("rs_busy", busy, 1'b1);
      check_eq("rs_ready", byte_ready, 1'b1);
      @(posedge clk); #1;
      load_image(1'b1, 1, 0);

      // Reset in the middle of word 1; start during RECV is ignored.
      start_pulse();
      img[0] = $urandom;
      img[1] = $urandom;
      send_word(0, 0);
      send_byte(img[1][7:0], 0);
      send_byte(img[1][15:8], 0);
      start_pulse();
      @(negedge clk);
      check_eq("mid_busy", busy, 1'b1);
      check_eq("mid_ready", byte_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      check_eq("rst_q_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      img[0] = $urandom;
      img[1] = $urandom;
      load_image(1'b1, 0, 0);

      // Random images, random gaps, mostly good checksums.
      for (int r = 0; r < 24; r++) begin
         start_pulse();
         img[0] = $urandom;
         img[1] = $urandom;
         load_image($urandom_range(3, 0) != 0, 3, 0);
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
